// File: rtl/dff_response_checker.sv
// Response checker for a storage DUT: compares q_obs against d_drv delayed by LATENCY
// edges for NUM_CHECKS consecutive cycles and reports counts and the first mismatch.
module dff_response_checker #(
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned NUM_CHECKS = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] d_drv,
    input  logic [WIDTH-1:0] q_obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] chk_count,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_obs
);

    localparam int unsigned FILL_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]  CHK_LAST  = CNT_W'(NUM_CHECKS);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [FILL_W-1:0] fill_cnt;
    logic [WIDTH-1:0]  pipe [LATENCY];
    logic [WIDTH-1:0]  exp_c;
    logic              mism_c;
    logic [CNT_W-1:0]  chk_next_c;

    // Expected value is the pipe tail; X/Z on q_obs counts as a mismatch.
    assign exp_c      = pipe[LATENCY-1];
    assign mism_c     = (q_obs !== exp_c);
    assign chk_next_c = chk_count + CNT_W'(1);

    // Delay pipe runs in every state so it is already primed when a run starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d_drv;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Run control with registered status outputs; outputs follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            fill_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            chk_count     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_obs <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= FILL;
                        fill_cnt      <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        chk_count     <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        first_err_exp <= '0;
                        first_err_obs <= '0;
                    end
                end
                FILL: begin
                    if (fill_cnt == FILL_LAST) begin
                        state <= CHECK;
                    end else begin
                        fill_cnt <= fill_cnt + FILL_W'(1);
                    end
                end
                CHECK: begin
                    chk_count <= chk_next_c;
                    if (mism_c) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        // err_count never returns to 0 within a run, so zero marks the first miss.
                        if (err_count == '0) begin
                            first_err_idx <= chk_count;
                            first_err_exp <= exp_c;
                            first_err_obs <= q_obs;
                        end
                    end
                    if (chk_next_c == CHK_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mism_c;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule
